// File: rtl/wb_fifo_pkg.sv
// Shared register map, STATUS bit layout and response encoding for the fifo0 Wishbone slave.
package wb_fifo_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_RX_UDF      = 5;
    localparam int ST_IRQ_EN      = 6;
    localparam int ST_TX_CNT_LSB  = 8;
    localparam int ST_RX_CNT_LSB  = 16;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } rsp_e;

endpackage

// File: rtl/wb_fifo_sync_fifo.sv
// First-word-fall-through register FIFO; head is combinational, zero while empty.
// Push is refused when full and pop when empty, both judged on the pre-edge count.
module wb_fifo_sync_fifo #(
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [DW-1:0]         push_data_i,
    input  logic                  pop_i,
    output logic [DW-1:0]         head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic slave with TX/RX FIFOs; one registered response per request (1 cycle), one beat per 2 cycles.
// Full TX / empty RX set sticky flags and ack, or answer with retry when WB_FIFO_RTY_EN is defined.
module wb_fifo_slave
    import wb_fifo_pkg::*;
#(
    parameter int DW            = 32,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [DW-1:0] tx_tdata_o,
    output logic          tx_tvalid_o,
    input  logic          tx_tready_i,
    input  logic [DW-1:0] rx_tdata_i,
    input  logic          rx_tvalid_i,
    output logic          rx_tready_o,
    output logic          irq_o
);

    logic                   ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0]            dat_q, dat_d, status;
    logic                   tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d, irq_en_q, irq_en_d;
    logic                   req, rsp_vld, st_wr, tx_push, rx_pop, tx_ovf_set, rx_udf_set;
    rsp_e                   rsp;
    logic [DW-1:0]          tx_head, rx_head;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic                   tx_full, tx_empty, rx_full, rx_empty;

    wb_fifo_sync_fifo #(.DW(DW), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_i       (wb_clk_i),
        .rst_n_i     (wb_rst_n_i),
        .push_i      (tx_push),
        .push_data_i (wb_dat_i[DW-1:0]),
        .pop_i       (tx_tvalid_o & tx_tready_i),
        .head_o      (tx_head),
        .count_o     (tx_count),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    wb_fifo_sync_fifo #(.DW(DW), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_i       (wb_clk_i),
        .rst_n_i     (wb_rst_n_i),
        .push_i      (rx_tvalid_i & rx_tready_o),
        .push_data_i (rx_tdata_i),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .count_o     (rx_count),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    assign tx_tdata_o  = tx_head;
    assign tx_tvalid_o = ~tx_empty;
    assign rx_tready_o = ~rx_full;
    assign irq_o       = irq_en_q & ~rx_empty;
    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
`ifdef WB_FIFO_RTY_EN
    assign wb_rty_o    = rty_q;
`else
    assign wb_rty_o    = 1'b0;
`endif

    // A pending response blocks the next request, giving one beat per two cycles.
    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o & ~wb_rty_o;

    always_comb begin
        status = '0;
        status[ST_TX_FULL]                = tx_full;
        status[ST_TX_EMPTY]               = tx_empty;
        status[ST_RX_FULL]                = rx_full;
        status[ST_RX_EMPTY]               = rx_empty;
        status[ST_TX_OVF]                 = tx_ovf_q;
        status[ST_RX_UDF]                 = rx_udf_q;
        status[ST_IRQ_EN]                 = irq_en_q;
        status[ST_TX_CNT_LSB +: 8]        = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]        = 8'(rx_count);
    end

    always_comb begin
        rsp_vld    = 1'b0;
        rsp        = RSP_ACK;
        dat_d      = '0;
        st_wr      = 1'b0;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        tx_ovf_set = 1'b0;
        rx_udf_set = 1'b0;
        if (req) begin
            rsp_vld = 1'b1;
            if (wb_sel_i != 4'hf) begin
                rsp = RSP_ERR;
            end else if (wb_adr_i[2] == ADDR_STATUS) begin
                if (wb_we_i) st_wr = 1'b1;
                else         dat_d = status;
            end else if (wb_we_i) begin
                if (!tx_full) tx_push = 1'b1;
`ifdef WB_FIFO_RTY_EN
                else          rsp = RSP_RTY;
`else
                else          tx_ovf_set = 1'b1;
`endif
            end else begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    dat_d  = 32'(rx_head);
                end
`ifdef WB_FIFO_RTY_EN
                else rsp = RSP_RTY;
`else
                else rx_udf_set = 1'b1;
`endif
            end
        end
        ack_d = rsp_vld && (rsp == RSP_ACK);
        err_d = rsp_vld && (rsp == RSP_ERR);
        rty_d = rsp_vld && (rsp == RSP_RTY);
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    assign tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(st_wr & wb_dat_i[ST_TX_OVF]));
    assign rx_udf_d = rx_udf_set | (rx_udf_q & ~(st_wr & wb_dat_i[ST_RX_UDF]));
    assign irq_en_d = st_wr ? wb_dat_i[ST_IRQ_EN] : irq_en_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            dat_q    <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            rty_q    <= rty_d;
            dat_q    <= dat_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
            irq_en_q <= irq_en_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i, rty_q};

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Self-checking bench for wb_fifo_slave: vector table for single bus beats, queues as TX/RX scoreboards.
module tb_wb_fifo_slave;

`ifdef WB_FIFO_RTY_EN
    localparam bit RTY = 1'b1;
`else
    localparam bit RTY = 1'b0;
`endif
    localparam logic [2:0] R_ACK   = 3'b001;
    localparam logic [2:0] R_ERR   = 3'b010;
    localparam logic [2:0] R_RTY   = 3'b100;
    localparam logic [2:0] R_LIMIT = RTY ? R_RTY : R_ACK;
    localparam logic [31:0] A_DAT  = 32'hC000_0000;
    localparam logic [31:0] A_ST   = 32'hC000_0004;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [2:0]  wb_cti = '0;
    logic [1:0]  wb_bte = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] tx_tdata_o, rx_tdata = '0;
    logic        tx_tvalid_o, tx_tready = 1'b0, rx_tvalid = 1'b0, rx_tready_o, irq_o;

    int n_checks = 0, n_pass = 0;
    logic [31:0] tx_q[$], rx_q[$];
    logic        rsp_irq;

    always #5 clk = ~clk;

    wb_fifo_slave dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_cti_i(wb_cti), .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .tx_tdata_o(tx_tdata_o),
        .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready), .rx_tdata_i(rx_tdata),
        .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready_o), .irq_o(irq_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [2:0]  rsp;
        logic [31:0] exp_dat;
        bit          chk_dat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                                input logic [3:0] sel, input logic [2:0] rsp,
                                input logic [31:0] exp_dat, input bit chk_dat);
        vec_t v;
        v.adr = adr; v.we = we; v.wdat = wdat; v.sel = sel;
        v.rsp = rsp; v.exp_dat = exp_dat; v.chk_dat = chk_dat;
        return v;
    endfunction

    // Called just after a rising edge; request is sampled on the next edge, response one cycle later.
    task automatic bus_op(input string nm, input logic [31:0] adr, input logic we,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output logic [31:0] rd, output logic [2:0] rsp);
        wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        rd = wb_dat_o;
        rsp = {wb_rty_o, wb_err_o, wb_ack_o};
        rsp_irq = irq_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        check({nm, "_rsp_drop"}, 32'({wb_rty_o, wb_err_o, wb_ack_o}), 32'd0);
    endtask

    task automatic do_vec(input string nm, input vec_t v);
        logic [31:0] rd;
        logic [2:0]  r;
        bus_op(nm, v.adr, v.we, v.wdat, v.sel, rd, r);
        check({nm, "_rsp"}, 32'(r), 32'(v.rsp));
        if (v.chk_dat) check({nm, "_dat"}, rd, v.exp_dat);
        if (v.we && !v.adr[2] && v.sel == 4'hf && tx_q.size() < 16) tx_q.push_back(v.wdat);
    endtask

    task automatic rd_data(input string nm);
        logic [31:0] e;
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 32'd0;
        do_vec(nm, mk(A_DAT, 1'b0, 0, 4'hf, (e == 0 && !RTY) || e != 0 ? R_ACK : R_RTY, e, 1'b1));
    endtask

    task automatic drain_tx(input string nm);
        tx_tready = 1'b1;
        for (int i = 0; i < 64 && tx_q.size() > 0; i++) begin
            logic [31:0] e;
            e = tx_q.pop_front();
            check($sformatf("%s_vld%0d", nm, i), 32'(tx_tvalid_o), 32'd1);
            check($sformatf("%s_dat%0d", nm, i), tx_tdata_o, e);
            @(posedge clk); #1;
        end
        tx_tready = 1'b0;
        check({nm, "_empty"}, 32'(tx_tvalid_o), 32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(A_ST,          1'b0, 0,     4'hf, R_ACK, 32'h0000_000A, 1'b1);
        tbl[1]  = mk(A_DAT,         1'b1, 'h11,  4'hf, R_ACK, 0, 1'b0);
        tbl[2]  = mk(A_DAT,         1'b1, 'h22,  4'hf, R_ACK, 0, 1'b0);
        tbl[3]  = mk(A_DAT,         1'b1, 'h33,  4'hf, R_ACK, 0, 1'b0);
        tbl[4]  = mk(32'hFFFF_FFFC, 1'b0, 0,     4'hf, R_ACK, 32'h0000_0308, 1'b1);
        tbl[5]  = mk(A_DAT,         1'b1, 'h44,  4'h1, R_ERR, 0, 1'b0);
        tbl[6]  = mk(A_DAT,         1'b0, 0,     4'h3, R_ERR, 0, 1'b0);
        tbl[7]  = mk(A_ST,          1'b0, 0,     4'hf, R_ACK, 32'h0000_0308, 1'b1);
        tbl[8]  = mk(A_ST,          1'b1, 'h40,  4'hf, R_ACK, 0, 1'b0);
        tbl[9]  = mk(32'h0000_0004, 1'b0, 0,     4'hf, R_ACK, 32'h0000_0348, 1'b1);
        tbl[10] = mk(A_ST,          1'b1, 'h30,  4'hf, R_ACK, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack_o), 0);
        check("rst_err", 32'(wb_err_o), 0);
        check("rst_rty", 32'(wb_rty_o), 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_tvalid", 32'(tx_tvalid_o), 0);
        check("rst_tdata", tx_tdata_o, 0);
        check("rst_rready", 32'(rx_tready_o), 1);
        check("rst_irq", 32'(irq_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_vec($sformatf("vec%0d", i), tbl[i]);
            if (i == 0) check("vec0_irq", 32'(rsp_irq), 0);
        end
        do_vec("st_irqoff", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h0000_0308, 1'b1));
        drain_tx("drain3");

        // Fill TX, then one write beyond capacity.
        for (int i = 0; i < 16; i++)
            do_vec($sformatf("fill%0d", i), mk(A_DAT, 1'b1, 32'h100 + i, 4'hf, R_ACK, 0, 1'b0));
        do_vec("ovf_wr", mk(A_DAT, 1'b1, 32'hDEAD, 4'hf, R_LIMIT, 0, RTY));
        do_vec("ovf_st", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, RTY ? 32'h1009 : 32'h1019, 1'b1));
        do_vec("ovf_clr", mk(A_ST, 1'b1, 32'h10, 4'hf, R_ACK, 0, 1'b0));
        do_vec("ovf_st2", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h1009, 1'b1));
        drain_tx("drain16");

        // Single RX word with interrupt enabled.
        do_vec("irq_en", mk(A_ST, 1'b1, 32'h40, 4'hf, R_ACK, 0, 1'b0));
        rx_tdata = 32'hA5; rx_tvalid = 1'b1; rx_q.push_back(32'hA5);
        @(posedge clk); #1;
        rx_tvalid = 1'b0;
        check("irq_set", 32'(irq_o), 1);
        rd_data("rx_a5");
        check("irq_clr", 32'(rsp_irq), 0);
        rd_data("rx_empty");
        do_vec("udf_st", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, RTY ? 32'h4A : 32'h6A, 1'b1));
        do_vec("udf_clr", mk(A_ST, 1'b1, 32'h60, 4'hf, R_ACK, 0, 1'b0));
        do_vec("udf_st2", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h4A, 1'b1));

        // Overfill RX from the stream side.
        rx_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_tdata = 32'hB0 + i;
            check($sformatf("rx_rdy%0d", i), 32'(rx_tready_o), 32'(rx_q.size() < 16));
            if (rx_q.size() < 16) rx_q.push_back(rx_tdata);
            @(posedge clk); #1;
        end
        rx_tvalid = 1'b0;
        check("rx_full_rdy", 32'(rx_tready_o), 0);
        check("rx_full_irq", 32'(irq_o), 1);
        do_vec("rx_full_st", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h0010_0046, 1'b1));
        for (int i = 0; i < 16; i++) rd_data($sformatf("rx_rd%0d", i));
        do_vec("rx_done_st", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h4A, 1'b1));
        check("rx_done_irq", 32'(irq_o), 0);

        // Back-to-back strobe: responses every other cycle.
        wb_adr = A_ST; wb_we = 1'b0; wb_sel = 4'hf; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_ack%0d", i), 32'(wb_ack_o), 32'(i % 2 == 0));
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;

        // Reset with 5 words queued and a write pending.
        for (int i = 0; i < 5; i++)
            do_vec($sformatf("pre_rst%0d", i), mk(A_DAT, 1'b1, 32'h200 + i, 4'hf, R_ACK, 0, 1'b0));
        wb_adr = A_DAT; wb_we = 1'b1; wb_dat = 32'h77; wb_sel = 4'hf; wb_cyc = 1'b1; wb_stb = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(tx_tvalid_o), 0);
        @(posedge clk); #1;
        check("mid_rst_ack", 32'(wb_ack_o), 0);
        rst_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tx_q.delete();
        @(posedge clk); #1;
        check("post_rst_ack", 32'(wb_ack_o), 0);
        check("post_rst_tvalid", 32'(tx_tvalid_o), 0);
        do_vec("post_rst_st", mk(A_ST, 1'b0, 0, 4'hf, R_ACK, 32'h0000_000A, 1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
